// File: rtl/deemph_stereo_sched_if.sv
// Stereo de-emphasis FIFO-side bundle: two input FIFO read ports, two output FIFO write ports
// and the scheduler busy flag.
interface deemph_stereo_sched_if #(
  parameter int DEEMPH_DATA_WIDTH = 32
);
  logic [DEEMPH_DATA_WIDTH-1:0] din_l;
  logic                         in_empty_l;
  logic                         in_rd_en_l;
  logic [DEEMPH_DATA_WIDTH-1:0] din_r;
  logic                         in_empty_r;
  logic                         in_rd_en_r;
  logic [DEEMPH_DATA_WIDTH-1:0] dout_l;
  logic                         out_full_l;
  logic                         out_wr_en_l;
  logic [DEEMPH_DATA_WIDTH-1:0] dout_r;
  logic                         out_full_r;
  logic                         out_wr_en_r;
  logic                         busy;

  modport slave (
    input  din_l, in_empty_l, din_r, in_empty_r, out_full_l, out_full_r,
    output in_rd_en_l, in_rd_en_r, dout_l, out_wr_en_l, dout_r, out_wr_en_r, busy
  );

  modport master (
    output din_l, in_empty_l, din_r, in_empty_r, out_full_l, out_full_r,
    input  in_rd_en_l, in_rd_en_r, dout_l, out_wr_en_l, dout_r, out_wr_en_r, busy
  );
endinterface

// File: rtl/deemph_stereo_sched.sv
// Stereo de-emphasis scheduler: one shared multiply/accumulate engine computes
// y = DQ(x*B0) + DQ(x1*B1) + DQ(y1*A0) for left and right, served round-robin.
module deemph_stereo_sched #(
  parameter int DEEMPH_DATA_WIDTH = 32,
  parameter int BITS              = 10,
  parameter int B0                = 178,
  parameter int B1                = 178,
  parameter int A0                = -666
) (
  input  logic                   clock,
  input  logic                   reset,
  deemph_stereo_sched_if.slave   bus
);
  localparam int W = DEEMPH_DATA_WIDTH;
  localparam logic signed [W-1:0] C_B0 = W'(B0);
  localparam logic signed [W-1:0] C_B1 = W'(B1);
  localparam logic signed [W-1:0] C_A0 = W'(A0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MUL0  = 3'd2,
    S_MUL1  = 3'd3,
    S_MUL2  = 3'd4,
    S_SUM   = 3'd5,
    S_WRITE = 3'd6
  } state_t;

  function automatic logic signed [2*W-1:0] sext(input logic [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

  state_t                r_state;
  logic                  r_ch;
  logic                  r_rr;
  logic                  r_busy;
  logic                  r_wr_l;
  logic                  r_wr_r;
  logic signed [W-1:0]   r_x_cur;
  logic signed [W-1:0]   r_acc;
  logic signed [W-1:0]   r_x_hist_l;
  logic signed [W-1:0]   r_x_hist_r;
  logic signed [W-1:0]   r_y_hist_l;
  logic signed [W-1:0]   r_y_hist_r;
  logic signed [W-1:0]   r_dout_l;
  logic signed [W-1:0]   r_dout_r;

  logic                  w_elig_l;
  logic                  w_elig_r;
  logic                  w_grant;
  logic                  w_grant_ch;
  logic                  w_take;
  logic signed [W-1:0]   w_x_hist;
  logic signed [W-1:0]   w_y_hist;
  logic signed [2*W-1:0] w_op_a;
  logic signed [2*W-1:0] w_op_b;
  logic signed [2*W-1:0] w_prod;
  logic signed [W-1:0]   w_dq;

  assign w_elig_l = ~bus.in_empty_l & ~bus.out_full_l;
  assign w_elig_r = ~bus.in_empty_r & ~bus.out_full_r;

  // Round-robin only matters on a tie; a lone eligible channel always wins.
  always_comb begin
    w_grant    = 1'b0;
    w_grant_ch = r_rr;
    if (w_elig_l && w_elig_r) begin
      w_grant    = 1'b1;
      w_grant_ch = r_rr;
    end else if (w_elig_l) begin
      w_grant    = 1'b1;
      w_grant_ch = 1'b0;
    end else if (w_elig_r) begin
      w_grant    = 1'b1;
      w_grant_ch = 1'b1;
    end else begin
      w_grant    = 1'b0;
      w_grant_ch = r_rr;
    end
  end

  // The read strobe must coincide with the IDLE decision so din is valid in LOAD.
  assign w_take         = (r_state == S_IDLE) && !reset && w_grant;
  assign bus.in_rd_en_l = w_take && !w_grant_ch;
  assign bus.in_rd_en_r = w_take && w_grant_ch;

  assign w_x_hist = r_ch ? r_x_hist_r : r_x_hist_l;
  assign w_y_hist = r_ch ? r_y_hist_r : r_y_hist_l;

  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    case (r_state)
      S_MUL0: begin
        w_op_a = sext(r_x_cur);
        w_op_b = sext(C_B0);
      end
      S_MUL1: begin
        w_op_a = sext(w_x_hist);
        w_op_b = sext(C_B1);
      end
      S_MUL2: begin
        w_op_a = sext(w_y_hist);
        w_op_b = sext(C_A0);
      end
      default: begin
        w_op_a = '0;
        w_op_b = '0;
      end
    endcase
  end

  assign w_prod = w_op_a * w_op_b;
  assign w_dq   = W'(w_prod >>> BITS);

  // Sequencer: one tap per cycle, history and output committed together in SUM.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ch       <= 1'b0;
      r_rr       <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_l     <= 1'b0;
      r_wr_r     <= 1'b0;
      r_x_cur    <= '0;
      r_acc      <= '0;
      r_x_hist_l <= '0;
      r_x_hist_r <= '0;
      r_y_hist_l <= '0;
      r_y_hist_r <= '0;
      r_dout_l   <= '0;
      r_dout_r   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_ch    <= w_grant_ch;
            r_rr    <= ~w_grant_ch;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          r_x_cur <= r_ch ? bus.din_r : bus.din_l;
          r_state <= S_MUL0;
        end
        S_MUL0: begin
          r_acc   <= w_dq;
          r_state <= S_MUL1;
        end
        S_MUL1: begin
          r_acc   <= r_acc + w_dq;
          r_state <= S_MUL2;
        end
        S_MUL2: begin
          r_acc   <= r_acc + w_dq;
          r_state <= S_SUM;
        end
        S_SUM: begin
          if (r_ch) begin
            r_x_hist_r <= r_x_cur;
            r_y_hist_r <= r_acc;
            r_dout_r   <= r_acc;
            r_wr_r     <= 1'b1;
          end else begin
            r_x_hist_l <= r_x_cur;
            r_y_hist_l <= r_acc;
            r_dout_l   <= r_acc;
            r_wr_l     <= 1'b1;
          end
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_wr_l  <= 1'b0;
          r_wr_r  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_wr_l  <= 1'b0;
          r_wr_r  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dout_l      = r_dout_l;
  assign bus.dout_r      = r_dout_r;
  assign bus.out_wr_en_l = r_wr_l;
  assign bus.out_wr_en_r = r_wr_r;
  assign bus.busy        = r_busy;
endmodule

// File: doc/deemph_stereo_sched.md
Name: deemph_stereo_sched

Overview:
- Stereo de-emphasis scheduler. Time-multiplexes one fixed-coefficient first-order IIR multiply/accumulate engine between the left and right audio channels.
- Sits after the stereo demux and before the audio output FIFOs.
- Arbitrates between the two input FIFOs with fair round-robin and keeps per-channel filter history (x[n-1], y[n-1]).
- Sequences the shared multiplier through the three filter taps, then writes each result to that channel's output FIFO.

Parameters:
- DEEMPH_DATA_WIDTH, 32, sample width in bits, two's complement.
- BITS, 10, fixed-point fraction bits; dequantize is an arithmetic right shift by BITS.
- B0, 178, feed-forward coefficient applied to x[n].
- B1, 178, feed-forward coefficient applied to x[n-1].
- A0, -666, feedback coefficient applied to y[n-1].

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- din_l  in  DEEMPH_DATA_WIDTH  left input FIFO data
- in_empty_l  in  1  left input FIFO empty
- in_rd_en_l  out  1  left input FIFO read strobe
- din_r  in  DEEMPH_DATA_WIDTH  right input FIFO data
- in_empty_r  in  1  right input FIFO empty
- in_rd_en_r  out  1  right input FIFO read strobe
- dout_l  out  DEEMPH_DATA_WIDTH  left output data
- out_full_l  in  1  left output FIFO full
- out_wr_en_l  out  1  left output FIFO write strobe
- dout_r  out  DEEMPH_DATA_WIDTH  right output data
- out_full_r  in  1  right output FIFO full
- out_wr_en_r  out  1  right output FIFO write strobe
- busy  out  1  high while a sample is in flight (any state other than IDLE)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset:
  - all strobes 0, busy 0, dout_l = dout_r = 0.
  - x_hist_l/r = 0, y_hist_l/r = 0, accumulator = 0.
  - rr pointer = LEFT; state = IDLE.
- Eligibility: a channel is eligible when its in_empty = 0 and its out_full = 0, both sampled in IDLE.
  - A channel with data but a full output is skipped.
  - The other channel is served if it is eligible.
- Arbitration in IDLE:
  - If both channels are eligible, grant the channel named by the rr pointer.
  - If only one is eligible, grant it.
  - After every grant, the rr pointer = the channel not granted.
- FSM: IDLE -> LOAD -> MUL0 -> MUL1 -> MUL2 -> SUM -> WRITE -> IDLE.
  - IDLE: evaluate eligibility. On a grant, assert that channel's in_rd_en for exactly this cycle, latch the channel select, and go to LOAD.
  - LOAD: capture din of the granted channel into x_cur. The FIFO output is valid one cycle after rd_en.
  - MUL0: acc = DQ(x_cur * B0).
  - MUL1: acc += DQ(x_hist[ch] * B1).
  - MUL2: acc += DQ(y_hist[ch] * A0).
  - SUM: x_hist[ch] = x_cur; y_hist[ch] = acc; dout[ch] = acc.
  - WRITE: assert out_wr_en[ch] for exactly one cycle, then go to IDLE.
- Shared multiplier: exactly one signed multiply per cycle. Operands are sign-extended to 2*W; the product is 2*W wide; DQ(p) = p >>> BITS, truncated to W bits. Accumulation wraps modulo 2^W with no saturation.
- Timing: latency from in_rd_en to out_wr_en is 6 cycles. Throughput is one sample per 7 cycles, combined across both channels.
- Output FIFO space: only this block writes the output FIFOs, so space checked at grant is guaranteed at WRITE. out_full is not rechecked in WRITE.
- Channel independence: the history of one channel is never read or modified while the other channel is being processed.
- dout of the idle channel holds its last written value.
- At most one in_rd_en and at most one out_wr_en is high in any cycle; a read and a write are never in the same cycle.
- Reset asserted mid-sample: abort immediately, return to IDLE, clear all history. The in-flight sample is dropped (it was already read) and no write is issued.
- in_empty toggling after grant has no effect.

Test Plan:
- Left only, histories zero: din_l = 1024, then din_l = 1024 again -> dout_l = 178 on the first out_wr_en_l (6 cycles after in_rd_en_l), then dout_l = 240 (178 + 178 + DQ(-666*178) = 356 - 116). No right strobes at any time.
- Negative input after reset: din_r = -1024 -> dout_r = -178. Left history stays 0, verified by a following din_l = 1024 giving dout_l = 178.
- Both channels always eligible, 8 samples each -> grants alternate L, R, L, R, ... starting LEFT. Reads are spaced 7 cycles apart, and each channel's outputs match a software model.
- out_full_l = 1 with both inputs non-empty -> only the right channel is served. When out_full_l falls, left is granted at the next IDLE.
- Assert reset during MUL1 of a left sample -> no out_wr_en_l. After reset, din_l = 1024 gives dout_l = 178, confirming history was cleared.
- Large input din_l = 0x7FFFFFFF twice -> result wraps modulo 2^32 and matches the model's truncation; no X values on dout_l.
